// File: rtl/td4_control_pkg.sv
// ---------------------------------------------------------------------------
// td4_control_pkg
// Shared definitions for the TD4 4-bit CPU controller: data/instruction
// widths, opcode encodings, the run/pause mode enum and a 4-bit adder helper
// that returns the carry-out in bit 4.
// ---------------------------------------------------------------------------
package td4_control_pkg;

  localparam int DATA_W = 4;
  localparam int INSN_W = 8;

  localparam logic [3:0] OP_ADD_A   = 4'b0000;
  localparam logic [3:0] OP_MOV_AB  = 4'b0001;
  localparam logic [3:0] OP_IN_A    = 4'b0010;
  localparam logic [3:0] OP_MOV_A   = 4'b0011;
  localparam logic [3:0] OP_MOV_BA  = 4'b0100;
  localparam logic [3:0] OP_ADD_B   = 4'b0101;
  localparam logic [3:0] OP_IN_B    = 4'b0110;
  localparam logic [3:0] OP_MOV_B   = 4'b0111;
  localparam logic [3:0] OP_OUT_B   = 4'b1001;
  localparam logic [3:0] OP_OUT_IMM = 4'b1011;
  localparam logic [3:0] OP_JNC     = 4'b1110;
  localparam logic [3:0] OP_JMP     = 4'b1111;

  typedef enum logic {
    MODE_PAUSE = 1'b0,
    MODE_RUN   = 1'b1
  } mode_e;

  // 4-bit add; result[4] is the carry-out used as the carry flag.
  function automatic logic [DATA_W:0] add4(input logic [DATA_W-1:0] x,
                                           input logic [DATA_W-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

endpackage

// File: rtl/td4_control_tick_gen.sv
// ---------------------------------------------------------------------------
// td4_tick_gen
// Run/pause/single-step sequencer. Produces a one-clock exec enable that
// advances the CPU by exactly one instruction.
//   clk      in  system clock, rising edge
//   n_reset  in  asynchronous active-low reset
//   run      in  level: 1 = free-run, 0 = pause
//   step     in  single-step request (rising edge detected here)
//   exec     out one-clock instruction enable
// In RUN the divider counts 0..TICK_DIV-1 and exec fires on the last count.
// In PAUSE the divider is held at 0 and each rising edge of step gives one exec.
// ---------------------------------------------------------------------------
module td4_tick_gen #(
  parameter int TICK_DIV = 12_000_000
) (
  input  logic clk,
  input  logic n_reset,
  input  logic run,
  input  logic step,
  output logic exec
);
  import td4_control_pkg::*;

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  mode_e            mode;
  logic [DIV_W-1:0] divider;
  logic             step_d;

  // Mode FSM, divider and step edge-detect history. Dropping run mid-count
  // clears the divider so the next RUN entry starts a full period.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      mode    <= MODE_PAUSE;
      divider <= '0;
      step_d  <= 1'b0;
    end else begin
      step_d <= step;
      case (mode)
        MODE_PAUSE: begin
          divider <= '0;
          if (run) mode <= MODE_RUN;
        end
        MODE_RUN: begin
          if (!run) begin
            mode    <= MODE_PAUSE;
            divider <= '0;
          end else if (divider == DIV_LAST) begin
            divider <= '0;
          end else begin
            divider <= divider + DIV_W'(1);
          end
        end
        default: mode <= MODE_PAUSE;
      endcase
    end
  end

  // exec is decoded from registered state only; in RUN it is suppressed in
  // the cycle where run has already fallen, and step is ignored.
  always_comb begin
    exec = 1'b0;
    if (mode == MODE_RUN) exec = run && (divider == DIV_LAST);
    else                  exec = step && !step_d;
  end

endmodule

// File: rtl/td4_control.sv
// ---------------------------------------------------------------------------
// td4_control
// Execution controller for the TD4 4-bit CPU. Holds PC/A/B/out/carry, drives
// the combinational instruction ROM address and decodes the returned word.
//   clk       in   system clock, rising edge
//   n_reset   in   asynchronous active-low reset
//   run       in   1 = free-run, 0 = pause
//   step      in   single-step request (rising edge)
//   in_port   in   [3:0] input switches for IN A / IN B
//   rom_data  in   [7:0] instruction at rom_addr (same cycle)
//   rom_addr  out  [3:0] program counter
//   out_port  out  [3:0] output LED register
//   reg_a     out  [3:0] register A
//   reg_b     out  [3:0] register B
//   carry     out  carry flag
//   halted    out  1 while the current instruction jumps to itself
// ---------------------------------------------------------------------------
module td4_control #(
  parameter int TICK_DIV = 12_000_000
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       run,
  input  logic       step,
  input  logic [3:0] in_port,
  input  logic [7:0] rom_data,
  output logic [3:0] rom_addr,
  output logic [3:0] out_port,
  output logic [3:0] reg_a,
  output logic [3:0] reg_b,
  output logic       carry,
  output logic       halted
);
  import td4_control_pkg::*;

  logic             exec;
  logic [3:0]       opcode;
  logic [3:0]       imm;
  logic [DATA_W:0]  sum_a;
  logic [DATA_W:0]  sum_b;
  logic [3:0]       nx_pc;
  logic [3:0]       nx_a;
  logic [3:0]       nx_b;
  logic [3:0]       nx_out;
  logic             nx_carry;

  td4_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .n_reset (n_reset),
    .run     (run),
    .step    (step),
    .exec    (exec)
  );

  assign opcode = rom_data[7:4];
  assign imm    = rom_data[3:0];
  assign sum_a  = add4(reg_a, imm);
  assign sum_b  = add4(reg_b, imm);

  // Self-jump detection; execution itself simply keeps looping.
  assign halted = (rom_data == {OP_JMP, rom_addr});

  // Instruction decode. Carry defaults to 0 so every non-ADD instruction,
  // JNC and NOP included, clears it.
  always_comb begin
    nx_pc    = rom_addr + 4'd1;
    nx_a     = reg_a;
    nx_b     = reg_b;
    nx_out   = out_port;
    nx_carry = 1'b0;
    case (opcode)
      OP_ADD_A:   {nx_carry, nx_a} = sum_a;
      OP_ADD_B:   {nx_carry, nx_b} = sum_b;
      OP_MOV_A:   nx_a   = imm;
      OP_MOV_B:   nx_b   = imm;
      OP_MOV_AB:  nx_a   = reg_b;
      OP_MOV_BA:  nx_b   = reg_a;
      OP_IN_A:    nx_a   = in_port;
      OP_IN_B:    nx_b   = in_port;
      OP_OUT_B:   nx_out = reg_b;
      OP_OUT_IMM: nx_out = imm;
      OP_JMP:     nx_pc  = imm;
      OP_JNC:     if (!carry) nx_pc = imm;
      default:    ;
    endcase
  end

  // Architectural state only moves on exec, so an async reset can never
  // leave a partially executed instruction behind.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rom_addr <= '0;
      reg_a    <= '0;
      reg_b    <= '0;
      out_port <= '0;
      carry    <= 1'b0;
    end else if (exec) begin
      rom_addr <= nx_pc;
      reg_a    <= nx_a;
      reg_b    <= nx_b;
      out_port <= nx_out;
      carry    <= nx_carry;
    end
  end

endmodule

// File: tb/tb_td4_control.sv
// ---------------------------------------------------------------------------
// tb_td4_control
// Self-checking bench for td4_control. Two instances share clock and reset:
// dut4 (TICK_DIV=4) for stepping, wrap, halt and mode edges, dut1 (TICK_DIV=1)
// for back-to-back execution. A reference model predicts each instruction;
// predictions are queued when the exec-causing stimulus is applied and popped
// after the exec edge.
// ---------------------------------------------------------------------------
module tb_td4_control;

  typedef struct packed {
    logic [3:0] pc;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] out;
    logic       carry;
  } cpu_t;

  logic       clk = 1'b0;
  logic       n_reset;
  logic [3:0] in_port;

  logic       run4, step4, carry4, halted4;
  logic [7:0] rom_data4;
  logic [3:0] rom_addr4, out_port4, reg_a4, reg_b4;
  logic [7:0] rom4 [16];

  logic       run1, step1, carry1, halted1;
  logic [7:0] rom_data1;
  logic [3:0] rom_addr1, out_port1, reg_a1, reg_b1;
  logic [7:0] rom1 [16];

  cpu_t m4, m1;
  cpu_t exp_q [$];
  int   checks = 0;
  int   errors = 0;

  assign rom_data4 = rom4[rom_addr4];
  assign rom_data1 = rom1[rom_addr1];

  always #5 clk = ~clk;

  td4_control #(.TICK_DIV(4)) dut4 (
    .clk(clk), .n_reset(n_reset), .run(run4), .step(step4), .in_port(in_port),
    .rom_data(rom_data4), .rom_addr(rom_addr4), .out_port(out_port4),
    .reg_a(reg_a4), .reg_b(reg_b4), .carry(carry4), .halted(halted4)
  );

  td4_control #(.TICK_DIV(1)) dut1 (
    .clk(clk), .n_reset(n_reset), .run(run1), .step(step1), .in_port(in_port),
    .rom_data(rom_data1), .rom_addr(rom_addr1), .out_port(out_port1),
    .reg_a(reg_a1), .reg_b(reg_b1), .carry(carry1), .halted(halted1)
  );

  // Reference model of one instruction.
  function automatic cpu_t model_exec(cpu_t s, logic [7:0] w, logic [3:0] inp);
    cpu_t       n;
    logic [4:0] t;
    logic [3:0] imm;
    n       = s;
    imm     = w[3:0];
    n.carry = 1'b0;
    n.pc    = s.pc + 4'd1;
    case (w[7:4])
      4'h0: begin t = {1'b0, s.a} + {1'b0, imm}; n.a = t[3:0]; n.carry = t[4]; end
      4'h5: begin t = {1'b0, s.b} + {1'b0, imm}; n.b = t[3:0]; n.carry = t[4]; end
      4'h3: n.a = imm;
      4'h7: n.b = imm;
      4'h1: n.a = s.b;
      4'h4: n.b = s.a;
      4'h2: n.a = inp;
      4'h6: n.b = inp;
      4'h9: n.out = s.b;
      4'hB: n.out = imm;
      4'hF: n.pc = imm;
      4'hE: if (!s.carry) n.pc = imm;
      default: ;
    endcase
    return n;
  endfunction

  task automatic checkOutput(string tag, logic [7:0] actual, logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic checkState(string tag, int which, cpu_t e);
    cpu_t       act;
    logic       h;
    logic [7:0] w;
    if (which == 4) begin
      act = {rom_addr4, reg_a4, reg_b4, out_port4, carry4};
      h   = halted4;
      w   = rom4[e.pc];
    end else begin
      act = {rom_addr1, reg_a1, reg_b1, out_port1, carry1};
      h   = halted1;
      w   = rom1[e.pc];
    end
    checkOutput({tag, ".pc"},    8'(act.pc),    8'(e.pc));
    checkOutput({tag, ".a"},     8'(act.a),     8'(e.a));
    checkOutput({tag, ".b"},     8'(act.b),     8'(e.b));
    checkOutput({tag, ".out"},   8'(act.out),   8'(e.out));
    checkOutput({tag, ".carry"}, 8'(act.carry), 8'(e.carry));
    checkOutput({tag, ".halt"},  8'(h),         8'(w == {4'hF, e.pc}));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Predict the next instruction of the chosen DUT and queue the result.
  task automatic applyStimulus(int which, logic [3:0] inp);
    in_port = inp;
    if (which == 4) begin
      m4 = model_exec(m4, rom4[m4.pc], inp);
      exp_q.push_back(m4);
    end else begin
      m1 = model_exec(m1, rom1[m1.pc], inp);
      exp_q.push_back(m1);
    end
  endtask

  task automatic popAndCheck(string tag, int which);
    cpu_t e;
    if (exp_q.size() == 0) begin
      checkOutput({tag, ".queue"}, 8'd0, 8'd1);
    end else begin
      e = exp_q.pop_front();
      checkState(tag, which, e);
    end
  endtask

  // One RUN period on dut4: three idle clocks then the exec clock.
  task automatic run_exec4(string tag, bit poke_step);
    for (int k = 0; k < 3; k++) begin
      if (poke_step && k == 0) step4 = 1'b1;
      tick();
      step4 = 1'b0;
      checkState({tag, ".hold"}, 4, m4);
    end
    applyStimulus(4, 4'd0);
    tick();
    popAndCheck(tag, 4);
  endtask

  initial begin
    cpu_t zero;
    int   n;
    zero    = '0;
    m4      = '0;
    m1      = '0;
    n_reset = 1'b0;
    run4 = 1'b0; step4 = 1'b0; run1 = 1'b0; step1 = 1'b0;
    in_port = 4'd0;
    for (int i = 0; i < 16; i++) begin
      rom4[i] = 8'h80;
      rom1[i] = 8'h80;
    end
    rom4[0] = 8'hB3;
    rom4[1] = 8'hB6;
    rom1[0] = 8'h3E; rom1[1] = 8'h03; rom1[2] = 8'hE0; rom1[3] = 8'h74;

    // Reset held while inputs wiggle.
    for (int i = 0; i < 6; i++) begin
      run4 = i[0]; step4 = i[1]; run1 = i[0]; step1 = i[1];
      tick();
    end
    checkState("reset4", 4, zero);
    checkState("reset1", 1, zero);
    run4 = 1'b0; step4 = 1'b0; run1 = 1'b0; step1 = 1'b0;
    tick();
    n_reset = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    checkState("idle4", 4, m4);
    checkState("idle1", 1, m1);

    // Single step.
    applyStimulus(4, 4'd0);
    step4 = 1'b1;
    tick();
    popAndCheck("step1", 4);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkState("step_held", 4, m4);
    end
    step4 = 1'b0;
    tick();
    checkState("step_low", 4, m4);
    applyStimulus(4, 4'd0);
    step4 = 1'b1;
    tick();
    popAndCheck("step2", 4);
    step4 = 1'b0;

    // Carry and JNC at TICK_DIV=1.
    run1 = 1'b1;
    tick();
    checkState("run1_enter", 1, m1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 4'd0);
      tick();
      popAndCheck($sformatf("carry_jnc%0d", i), 1);
    end
    run1 = 1'b0;
    tick();

    // PC wrap with NOPs at TICK_DIV=4; a step poke in RUN is ignored.
    rom4[0] = 8'h80;
    rom4[1] = 8'h80;
    run4 = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) run_exec4($sformatf("wrap%0d", i), i == 0);

    // Drop run at divider=2: no exec, then a full period after re-entry.
    tick();
    tick();
    run4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkState("run_drop", 4, m4);
    end
    run4 = 1'b1;
    tick();
    run_exec4("reenter", 1'b0);

    // Self-jump halt at address 9.
    rom4[9] = 8'hF9;
    n = 0;
    while (m4.pc != 4'd9 && n < 20) begin
      run_exec4("to_halt", 1'b0);
      n++;
    end
    checkOutput("halt_reached", 8'(rom_addr4), 8'd9);
    for (int i = 0; i < 50; i++) run_exec4("halt", 1'b0);

    // Asynchronous reset in the middle of a RUN period.
    #2;
    n_reset = 1'b0;
    #1;
    m4 = '0;
    m1 = '0;
    checkState("async_rst4", 4, zero);
    checkState("async_rst1", 1, zero);
    run4 = 1'b0;
    tick();
    n_reset = 1'b1;
    tick();

    // Remaining instructions on dut1 with varying switch input.
    rom1[0]  = 8'h20; rom1[1]  = 8'h56; rom1[2]  = 8'h5B; rom1[3]  = 8'h14;
    rom1[4]  = 8'h37; rom1[5]  = 8'h40; rom1[6]  = 8'h90; rom1[7]  = 8'h60;
    rom1[8]  = 8'h0F; rom1[9]  = 8'hEC; rom1[10] = 8'hEC; rom1[11] = 8'h80;
    rom1[12] = 8'hC3; rom1[13] = 8'hF5; rom1[14] = 8'h80; rom1[15] = 8'h80;
    run1 = 1'b1;
    tick();
    for (int i = 0; i < 24; i++) begin
      applyStimulus(1, 4'($urandom_range(0, 15)));
      tick();
      popAndCheck($sformatf("prog%0d", i), 1);
    end
    run1 = 1'b0;
    tick();

    checkOutput("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
